// File: rtl/spi_instr_loader_if.sv
// spi_instr_loader_if: SPI pins and instruction-regfile write port of spi_instr_loader
//   sclk, cs_n, mosi : SPI inputs from the host (mode 0, MSB first)
//   miso             : SPI status output
//   write_addr, data_in, write_en : regfile write port
//   core_hold        : holds pio_core off while a frame is active
//   frame_err        : one-clk pulse on a malformed frame
interface spi_instr_loader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
);
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  write_en;
    logic                  core_hold;
    logic                  frame_err;
    modport slave (
        input  sclk, cs_n, mosi,
        output miso, write_addr, data_in, write_en, core_hold, frame_err
    );
    modport master (
        output sclk, cs_n, mosi,
        input  miso, write_addr, data_in, write_en, core_hold, frame_err
    );
endinterface

// File: rtl/spi_instr_loader.sv
// spi_instr_loader: SPI target that loads PIO instruction words into the instruction regfile
//   clk  : system clock, must be >= 4x sclk
//   rst  : asynchronous reset, active-low
//   bus  : spi_instr_loader_if.slave (SPI pins, regfile write port, core_hold, frame_err)
//   Optional macro SPI_STATUS_EN: drives {3'b101, last write address} on miso during
//   the command byte; without it miso is tied to 0.
module spi_instr_loader #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    spi_instr_loader_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    typedef enum logic [1:0] {IDLE, CMD, DATA, DISCARD} state_t;
    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   rise, cs_fall, cs_rise;
    logic [DATA_WIDTH-2:0]  sh;
    logic [CW-1:0]          cnt;
    logic [7:0]             cmd;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   burst, pend;
    assign sclk_s  = sclk_q[SYNC_STAGES-1];
    assign cs_s    = cs_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_prev & ~cs_s;
    assign cs_fall = cs_prev & ~cs_s;
    assign cs_rise = ~cs_prev & cs_s;
    assign cmd     = {sh[6:0], mosi_s};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_q         <= '0;
            cs_q           <= '1;
            mosi_q         <= '0;
            sclk_prev      <= 1'b0;
            cs_prev        <= 1'b1;
            state          <= IDLE;
            sh             <= '0;
            cnt            <= '0;
            addr           <= '0;
            burst          <= 1'b0;
            pend           <= 1'b0;
            bus.write_addr <= '0;
            bus.data_in    <= '0;
            bus.write_en   <= 1'b0;
            bus.core_hold  <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            sclk_q        <= {sclk_q[SYNC_STAGES-2:0], bus.sclk};
            cs_q          <= {cs_q[SYNC_STAGES-2:0], bus.cs_n};
            mosi_q        <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev     <= sclk_s;
            cs_prev       <= cs_s;
            bus.core_hold <= ~cs_s;
            bus.write_en  <= 1'b0;
            bus.frame_err <= 1'b0;
            if (cs_rise) begin
                // a frame ending with a partly shifted byte or word is malformed
                state         <= IDLE;
                pend          <= 1'b0;
                bus.frame_err <= (state == CMD || state == DATA) && cnt != '0;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        state <= CMD;
                        cnt   <= '0;
                    end
                    CMD: if (rise) begin
                        sh  <= {sh[DATA_WIDTH-3:0], mosi_s};
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(7)) begin
                            cnt <= '0;
                            if (cmd[7:5] == 3'b001 || cmd[7:5] == 3'b010) begin
                                state <= DATA;
                                addr  <= cmd[ADDR_WIDTH-1:0];
                                burst <= cmd[6];
                            end else begin
                                state         <= DISCARD;
                                bus.frame_err <= 1'b1;
                            end
                        end
                    end
                    DATA: if (pend) begin
                        // strobe one clk after the word is registered; stay in DATA for it
                        bus.write_en <= 1'b1;
                        pend         <= 1'b0;
                        if (burst) addr <= addr + 1'b1;
                        else state <= DISCARD;
                    end else if (rise) begin
                        sh  <= {sh[DATA_WIDTH-3:0], mosi_s};
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(DATA_WIDTH - 1)) begin
                            cnt            <= '0;
                            bus.data_in    <= {sh, mosi_s};
                            bus.write_addr <= addr;
                            pend           <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
`ifdef SPI_STATUS_EN
    logic                  fall;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [7:0]            stat;
    assign fall = ~sclk_s & sclk_prev & ~cs_s;
    // the status MSB goes out at cs_n fall, the rest on sclk falling edges of byte 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_addr <= '0;
            stat      <= '0;
            bus.miso  <= 1'b0;
        end else begin
            if (bus.write_en) last_addr <= bus.write_addr;
            stat     <= (state == IDLE && cs_fall) ? {2'b01, 5'(last_addr), 1'b0} :
                        (state == CMD && fall) ? {stat[6:0], 1'b0} : stat;
            bus.miso <= (state == IDLE && cs_fall) ? 1'b1 :
                        (state == CMD && !cs_rise) ? (fall ? stat[7] : bus.miso) : 1'b0;
        end
    end
`else
    assign bus.miso = 1'b0;
`endif
endmodule
